// File: rtl/esp_resp_watch.sv
// esp_resp_watch: watches the ESP8266 UART RX byte stream after an AT command
// and reports OK, ERROR or TIMEOUT to the Wi-Fi command sequencer. It owns the
// millisecond timer's clear input (rst_timer) and reads back its cycles count.
// Optional feature macro: ESP_RESP_FAIL_EN -- when defined, a trailing "FAIL"
// also completes the watch with the ERROR result code.
module esp_resp_watch #(
    parameter int HIST_W   = 40,
    parameter int RST_HOLD = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] timeout_ms,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic [15:0] cycles,
    output logic        rst_timer,
    output logic        busy,
    output logic        done,
    output logic [1:0]  result,
    output logic [15:0] elapsed
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [1:0] RES_NONE    = 2'b00;
    localparam logic [1:0] RES_OK      = 2'b01;
    localparam logic [1:0] RES_ERROR   = 2'b10;
    localparam logic [1:0] RES_TIMEOUT = 2'b11;

    localparam logic [31:0] TOK_OK    = 32'h4F4B_0D0A;
    localparam logic [39:0] TOK_ERROR = 40'h45_5252_4F52;
`ifdef ESP_RESP_FAIL_EN
    localparam logic [31:0] TOK_FAIL  = 32'h4641_494C;
`endif

    localparam logic [1:0] HOLD_LAST = 2'(RST_HOLD - 1);

    state_t              state;
    logic [HIST_W-1:0]   hist;
    logic [HIST_W-1:0]   hist_next;
    logic [15:0]         tmo_lat;
    logic [1:0]          hold_cnt;
    logic                hit_ok;
    logic                hit_err;
    logic                hit_fail;
    logic                hit_tmo;

    // History including this cycle's byte, and the token/timeout matches on it
    always_comb begin
        hist_next = hist;
        if (rx_valid) begin
            hist_next = {hist[HIST_W-9:0], rx_data};
        end
        hit_ok  = rx_valid && (hist_next[31:0] == TOK_OK);
        hit_err = rx_valid && (hist_next[39:0] == TOK_ERROR);
`ifdef ESP_RESP_FAIL_EN
        hit_fail = rx_valid && (hist_next[31:0] == TOK_FAIL);
`else
        hit_fail = 1'b0;
`endif
        hit_tmo = (tmo_lat != 16'd0) && (cycles >= tmo_lat);
    end

    // Watch FSM with registered outputs; abort beats completion, OK > ERROR > FAIL > TIMEOUT
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rst_timer <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= RES_NONE;
            elapsed   <= 16'd0;
            hist      <= '0;
            tmo_lat   <= 16'd0;
            hold_cnt  <= 2'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    rst_timer <= 1'b1;
                    if (start) begin
                        tmo_lat  <= timeout_ms;
                        hist     <= '0;
                        result   <= RES_NONE;
                        busy     <= 1'b1;
                        hold_cnt <= 2'd0;
                        state    <= ARM;
                    end
                end
                ARM: begin
                    if (abort) begin
                        busy      <= 1'b0;
                        rst_timer <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        hist <= hist_next;
                        if (hold_cnt == HOLD_LAST) begin
                            rst_timer <= 1'b0;
                            state     <= WAIT;
                        end else begin
                            hold_cnt <= hold_cnt + 2'd1;
                        end
                    end
                end
                WAIT: begin
                    hist <= hist_next;
                    if (abort) begin
                        busy      <= 1'b0;
                        rst_timer <= 1'b1;
                        state     <= IDLE;
                    end else if (hit_ok || hit_err || hit_fail || hit_tmo) begin
                        if (hit_ok) begin
                            result <= RES_OK;
                        end else if (hit_err || hit_fail) begin
                            result <= RES_ERROR;
                        end else begin
                            result <= RES_TIMEOUT;
                        end
                        elapsed   <= cycles;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        rst_timer <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    rst_timer <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_esp_resp_watch.sv
// tb_esp_resp_watch: directed bench for esp_resp_watch. Inputs change #1 after
// the rising edge and outputs are examined at that same point, so a registered
// output seen after edge N is the value held during cycle N+1.
module tb_esp_resp_watch;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] timeout_ms;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] cycles;
    logic        rst_timer;
    logic        busy;
    logic        done;
    logic [1:0]  result;
    logic [15:0] elapsed;

    int checks;
    int errors;
    int done_seen;

    esp_resp_watch dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .timeout_ms (timeout_ms),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .cycles     (cycles),
        .rst_timer  (rst_timer),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .elapsed    (elapsed)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (done === 1'b1) done_seen++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    // Pulse start and step through ARM into WAIT
    task automatic begin_watch(input logic [15:0] tmo);
        timeout_ms = tmo;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (rst_timer !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
            result !== 2'b00 || elapsed !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset: rst_timer=%b busy=%b done=%b result=%b elapsed=%0d, expected 1 0 0 00 0",
                     rst_timer, busy, done, result, elapsed);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ok();
        logic [7:0] msg [8];
        msg = '{8'h41, 8'h54, 8'h0D, 8'h0A, 8'h4F, 8'h4B, 8'h0D, 8'h0A};
        cycles = 16'd0;
        timeout_ms = 16'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || rst_timer !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ok_arm: busy=%b rst_timer=%b, expected 1 1", busy, rst_timer);
        end
        tick();
        checks++;
        if (rst_timer !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ok_wait_entry: rst_timer=%b, expected 0", rst_timer);
        end
        cycles = 16'd5;
        done_seen = 0;
        for (int i = 0; i < 7; i++) send_byte(msg[i]);
        checks++;
        if (done_seen !== 0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ok_early: done_seen=%0d busy=%b, expected 0 1", done_seen, busy);
        end
        send_byte(msg[7]);
        checks++;
        if (done !== 1'b1 || result !== 2'b01 || elapsed !== 16'd5 ||
            busy !== 1'b0 || rst_timer !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ok_done: done=%b result=%b elapsed=%0d busy=%b rst_timer=%b, expected 1 01 5 0 1",
                     done, result, elapsed, busy, rst_timer);
        end
        tick();
        checks++;
        if (done !== 1'b0 || result !== 2'b01) begin
            errors++;
            $display("[TB] FAIL ok_pulse: done=%b result=%b, expected 0 01", done, result);
        end
    endtask

    task automatic test_timeout();
        cycles = 16'd0;
        begin_watch(16'd3);
        done_seen = 0;
        cycles = 16'd1;
        tick();
        cycles = 16'd2;
        tick();
        checks++;
        if (done_seen !== 0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tmo_early: done_seen=%0d busy=%b, expected 0 1", done_seen, busy);
        end
        cycles = 16'd3;
        tick();
        checks++;
        if (done !== 1'b1 || result !== 2'b11 || elapsed !== 16'd3) begin
            errors++;
            $display("[TB] FAIL tmo_done: done=%b result=%b elapsed=%0d, expected 1 11 3", done, result, elapsed);
        end
        cycles = 16'd0;
        tick();
    endtask

    task automatic test_error_priority();
        cycles = 16'd0;
        begin_watch(16'd3);
        cycles = 16'd1;
        send_byte(8'h45);
        send_byte(8'h52);
        send_byte(8'h52);
        send_byte(8'h4F);
        cycles = 16'd3;
        send_byte(8'h52);
        checks++;
        if (done !== 1'b1 || result !== 2'b10 || elapsed !== 16'd3) begin
            errors++;
            $display("[TB] FAIL err_prio: done=%b result=%b elapsed=%0d, expected 1 10 3", done, result, elapsed);
        end
        // OK completing on the timeout cycle also reports the token
        cycles = 16'd0;
        begin_watch(16'd2);
        send_byte(8'h4F);
        send_byte(8'h4B);
        send_byte(8'h0D);
        cycles = 16'd2;
        send_byte(8'h0A);
        checks++;
        if (done !== 1'b1 || result !== 2'b01) begin
            errors++;
            $display("[TB] FAIL ok_prio: done=%b result=%b, expected 1 01", done, result);
        end
        cycles = 16'd0;
        tick();
    endtask

    task automatic test_abort();
        cycles = 16'd0;
        begin_watch(16'd0);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || rst_timer !== 1'b1 || result !== 2'b00 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_state: busy=%b rst_timer=%b result=%b done=%b, expected 0 1 00 0",
                     busy, rst_timer, result, done);
        end
        done_seen = 0;
        send_byte(8'h4F);
        send_byte(8'h4B);
        send_byte(8'h0D);
        send_byte(8'h0A);
        tick();
        checks++;
        if (done_seen !== 0 || result !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_idle_bytes: done_seen=%0d result=%b busy=%b, expected 0 00 0",
                     done_seen, result, busy);
        end
        // abort in the same cycle as the completing byte wins
        begin_watch(16'd0);
        send_byte(8'h4F);
        send_byte(8'h4B);
        send_byte(8'h0D);
        done_seen = 0;
        abort = 1'b1;
        send_byte(8'h0A);
        abort = 1'b0;
        tick();
        checks++;
        if (done_seen !== 0 || result !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_vs_ok: done_seen=%0d result=%b busy=%b, expected 0 00 0",
                     done_seen, result, busy);
        end
        begin_watch(16'd0);
        send_byte(8'h4F);
        send_byte(8'h4B);
        send_byte(8'h0D);
        send_byte(8'h0A);
        checks++;
        if (done !== 1'b1 || result !== 2'b01) begin
            errors++;
            $display("[TB] FAIL abort_restart: done=%b result=%b, expected 1 01", done, result);
        end
    endtask

    task automatic test_back_to_back();
        // Previous task leaves done high right now; start is accepted in that cycle
        timeout_ms = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || result !== 2'b00 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_start: busy=%b result=%b done=%b, expected 1 00 0", busy, result, done);
        end
        tick();
        // start while busy in WAIT must not re-arm the timer
        timeout_ms = 16'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (rst_timer !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_start: rst_timer=%b busy=%b, expected 0 1", rst_timer, busy);
        end
        // latched timeout stays 0, so cycles=9 must not end the watch
        cycles = 16'd9;
        tick();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_start_tmo: busy=%b done=%b, expected 1 0", busy, done);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        cycles = 16'd0;
    endtask

    task automatic test_no_timeout();
        cycles = 16'd0;
        begin_watch(16'd0);
        done_seen = 0;
        for (int i = 0; i < 65536; i += 97) begin
            cycles = 16'(i);
            tick();
        end
        cycles = 16'hFFFF;
        tick();
        cycles = 16'd0;
        tick();
        checks++;
        if (done_seen !== 0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL notmo_sweep: done_seen=%0d busy=%b, expected 0 1", done_seen, busy);
        end
        cycles = 16'd7;
        send_byte(8'h4F);
        send_byte(8'h4B);
        send_byte(8'h0D);
        send_byte(8'h0A);
        tick();
        checks++;
        if (done_seen !== 1 || result !== 2'b01 || elapsed !== 16'd7) begin
            errors++;
            $display("[TB] FAIL notmo_ok: done_seen=%0d result=%b elapsed=%0d, expected 1 01 7",
                     done_seen, result, elapsed);
        end
    endtask

    task automatic test_reset_mid_watch();
        cycles = 16'd0;
        begin_watch(16'd0);
        send_byte(8'h4F);
        send_byte(8'h4B);
        send_byte(8'h0D);
        done_seen = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (rst_timer !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
            result !== 2'b00 || elapsed !== 16'd0) begin
            errors++;
            $display("[TB] FAIL rst_mid: rst_timer=%b busy=%b done=%b result=%b elapsed=%0d, expected 1 0 0 00 0",
                     rst_timer, busy, done, result, elapsed);
        end
        begin_watch(16'd0);
        send_byte(8'h0A);
        tick();
        checks++;
        if (done_seen !== 0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_hist: done_seen=%0d busy=%b, expected 0 1", done_seen, busy);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_fail_token();
        cycles = 16'd0;
        begin_watch(16'd5);
        cycles = 16'd1;
        done_seen = 0;
        send_byte(8'h46);
        send_byte(8'h41);
        send_byte(8'h49);
        send_byte(8'h4C);
`ifdef ESP_RESP_FAIL_EN
        checks++;
        if (done !== 1'b1 || result !== 2'b10 || elapsed !== 16'd1) begin
            errors++;
            $display("[TB] FAIL fail_tok: done=%b result=%b elapsed=%0d, expected 1 10 1", done, result, elapsed);
        end
`else
        tick();
        checks++;
        if (done_seen !== 0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fail_data: done_seen=%0d busy=%b, expected 0 1", done_seen, busy);
        end
        cycles = 16'd5;
        tick();
        checks++;
        if (done !== 1'b1 || result !== 2'b11 || elapsed !== 16'd5) begin
            errors++;
            $display("[TB] FAIL fail_tmo: done=%b result=%b elapsed=%0d, expected 1 11 5", done, result, elapsed);
        end
`endif
        cycles = 16'd0;
        tick();
    endtask

    // Run every scenario in order, then report
    initial begin
        checks     = 0;
        errors     = 0;
        done_seen  = 0;
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        timeout_ms = 16'd0;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        cycles     = 16'd0;
        test_reset();
        test_ok();
        test_timeout();
        test_error_priority();
        test_abort();
        test_back_to_back();
        test_no_timeout();
        test_reset_mid_watch();
        test_fail_token();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/esp_resp_watch.md
Name: esp_resp_watch

Overview:
- Consumes the millisecond `cycles` count from the ESP8266 timer block and owns that timer's `rst_timer` input.
- Watches the ESP8266 UART RX byte stream after an AT command is sent. Reports OK, ERROR or timeout to the command sequencer.
- Sits between the UART receiver, the timer and the Wi-Fi command FSM.

Parameters:
- HIST_W, 40, width of the byte history shift register: 5 bytes × 8 bits.
- RST_HOLD, 1, cycles `rst_timer` is held high in ARM before the timeout window opens; valid range 1–3.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  1-cycle pulse; begin watching for a response
- abort  in  1  1-cycle pulse; drop the current watch, no `done`
- timeout_ms  in  16  timeout in timer units (ms); latched on `start`; 0 = no timeout
- rx_data  in  8  received byte
- rx_valid  in  1  `rx_data` valid this cycle
- cycles  in  16  elapsed ms from the timer
- rst_timer  out  1  clear/hold the timer
- busy  out  1  watch in progress
- done  out  1  1-cycle pulse on completion
- result  out  2  00 none, 01 OK, 10 ERROR, 11 TIMEOUT; held until next accepted `start`
- elapsed  out  16  `cycles` value captured at completion

Behaviour:
- Reset values (synchronous, while `rst`=1): state IDLE, `rst_timer`=1, `busy`=0, `done`=0, `result`=00, `elapsed`=0, history=0, latched timeout=0.
- State IDLE:
  - `rst_timer`=1; `rx_valid` bytes are ignored.
  - `start`=1 → latch `timeout_ms`, clear history, clear `result` to 00, `busy`=1, go to ARM.
- State ARM:
  - `rst_timer`=1 for RST_HOLD cycles, so the timer's cycles/counter are zero, then go to WAIT.
  - `rx_valid` bytes arriving in ARM are shifted into history, not dropped.
- State WAIT:
  - `rst_timer`=0.
  - Each `rx_valid` byte shifts into the history LSB byte; the oldest byte falls off the top.
  - Match check uses the history including the byte arriving this cycle.
  - OK: the last 4 bytes are 0x4F 0x4B 0x0D 0x0A ("OK\r\n").
  - ERROR: the last 5 bytes are "ERROR" (0x45 0x52 0x52 0x4F 0x52).
  - TIMEOUT: latched timeout ≠ 0 and `cycles` ≥ latched timeout.
- Completion, registered at the same edge the condition is seen:
  - `result` set, `elapsed` ← `cycles`, `done`=1 for exactly one cycle, `busy`=0, `rst_timer`=1, go to IDLE.
  - Latency: byte completing a token at edge N → `done` high during cycle N+1.
- Priority when events coincide: OK > ERROR > TIMEOUT. A token completing in the same cycle the timeout is reached reports the token.
- `abort` in ARM or WAIT → IDLE next edge; `busy`=0, `rst_timer`=1, `result` unchanged (00), no `done`. `abort` beats any completion in the same cycle.
- `start` while `busy`=1 is ignored, including during ARM. `start` and `abort` together in IDLE: `start` wins.
- `start` in the cycle `done` is high is accepted, so back-to-back commands work.
- `rst` asserted mid-watch → all reset values next edge; no `done`.
- `timeout_ms`=0: waits indefinitely. Timer wrap at 65535 does not cause a timeout; only OK/ERROR/abort end the watch.
- The comparison is unsigned 16-bit. `timeout_ms`=1 completes once `cycles` reaches 1, about 1 ms after WAIT entry.

Optional Feature:
- Macro ESP_RESP_FAIL_EN.
- Defined: the last 4 bytes "FAIL" (0x46 0x41 0x49 0x4C) also complete the watch with `result`=10. Priority becomes OK > ERROR > FAIL > TIMEOUT.
- Undefined: "FAIL" is ordinary data and the watch continues.

Test Plan:
1. `start`, `timeout_ms`=100; feed "AT\r\nOK\r\n" at `cycles`=5 → `done` one cycle after the 0x0A byte, `result`=01, `elapsed`=5, `busy`=0, `rst_timer`=1.
2. `start`, `timeout_ms`=3, no bytes; drive `cycles` 0,1,2,3 → `done` when `cycles`=3, `result`=11, `elapsed`=3.
3. Bytes "ERROR" in WAIT with `cycles`=3 equal to `timeout_ms`=3 in the same cycle as the final 'R' → `result`=10, not 11.
4. `start`, then `abort` 2 cycles into WAIT, then "OK\r\n" → no `done`, `result`=00, `busy`=0; a new `start` then "OK\r\n" → `result`=01.
5. `timeout_ms`=0 and `cycles` swept 0→65535→0; then "OK\r\n" → only completion is OK, `result`=01.
6. `rst` asserted mid-WAIT after "OK\r" → outputs at reset values; after `start`, a lone "\n" does not match (history cleared).
7. With ESP_RESP_FAIL_EN defined, "FAIL" → `result`=10. With it undefined, the watch stays `busy` until timeout `result`=11.
